// File: rtl/chronologic.sv
// Period monitor for a slow periodic signal: measures rising-edge-to-rising-edge
// spacing in clk cycles, grades it against EXP_PERIOD +/- TOL and flags timeouts.
module chronologic #(
    parameter int CNT_W       = 16,
    parameter int EXP_PERIOD  = 10,
    parameter int TOL         = 0,
    parameter int SYNC_STAGES = 2,
    parameter int STAT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sig_in,
    output logic [CNT_W-1:0]  period_o,
    output logic              period_vld,
    output logic              pass_pulse,
    output logic              fail_pulse,
    output logic              timeout_o,
    output logic [STAT_W-1:0] pass_cnt,
    output logic [STAT_W-1:0] fail_cnt
);

    localparam logic [CNT_W-1:0] LIMIT  = CNT_W'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0] LO_LIM = CNT_W'(EXP_PERIOD - TOL);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d;
    logic                   s;
    logic                   rise;
    logic [CNT_W-1:0]       cnt;
    logic                   armed;
    logic                   in_tol;
    logic                   timeout_hit;

    assign s           = sync_q[SYNC_STAGES-1];
    assign rise        = s & ~s_d;
    assign in_tol      = (cnt >= LO_LIM) && (cnt <= LIMIT);
    // A rise on the same edge as the limit is a measurement, never a timeout.
    assign timeout_hit = armed & ~rise & (cnt == LIMIT);

    // Synchronizer and edge detector run regardless of en.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_d    <= s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= CNT_W'(1);
        end else if (!(&cnt)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed      <= 1'b0;
            period_o   <= '0;
            period_vld <= 1'b0;
            pass_pulse <= 1'b0;
            fail_pulse <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            period_vld <= 1'b0;
            pass_pulse <= 1'b0;
            fail_pulse <= 1'b0;
            if (!en) begin
                armed <= 1'b0;
            end else if (rise) begin
                armed <= 1'b1;
                if (armed) begin
                    period_o   <= cnt;
                    period_vld <= 1'b1;
                    pass_pulse <= in_tol;
                    fail_pulse <= ~in_tol;
                end
            end else if (timeout_hit) begin
                armed      <= 1'b0;
                fail_pulse <= 1'b1;
                timeout_o  <= 1'b1;
            end
        end
    end

    // Statistics count the pulse registered on the previous edge and saturate.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else begin
            if (pass_pulse && !(&pass_cnt)) pass_cnt <= pass_cnt + STAT_W'(1);
            if (fail_pulse && !(&fail_cnt)) fail_cnt <= fail_cnt + STAT_W'(1);
        end
    end

endmodule

// File: tb/tb_chronologic.sv
// Bench for chronologic: two builds (TOL=0 and TOL=1) share stimulus; a timing-level
// reference model predicts every pulse into per-build queues that a monitor drains.
module tb_chronologic;
    localparam int CNT_W    = 16;
    localparam int EXP      = 10;
    localparam int SYNC     = 2;
    localparam int STAT_W   = 8;
    localparam int STAT_MAX = (1 << STAT_W) - 1;
    localparam int W        = CNT_W + 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b1;
    logic sig_in = 1'b0;

    logic [CNT_W-1:0]  per0, per1;
    logic              vld0, vld1, pass0, pass1, fail0, fail1, tmo0, tmo1;
    logic [STAT_W-1:0] pc0, pc1, fc0, fc1;

    chronologic #(.CNT_W(CNT_W), .EXP_PERIOD(EXP), .TOL(0), .SYNC_STAGES(SYNC), .STAT_W(STAT_W)) dut0 (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .period_o(per0), .period_vld(vld0), .pass_pulse(pass0), .fail_pulse(fail0),
        .timeout_o(tmo0), .pass_cnt(pc0), .fail_cnt(fc0)
    );

    chronologic #(.CNT_W(CNT_W), .EXP_PERIOD(EXP), .TOL(1), .SYNC_STAGES(SYNC), .STAT_W(STAT_W)) dut1 (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .period_o(per1), .period_vld(vld1), .pass_pulse(pass1), .fail_pulse(fail1),
        .timeout_o(tmo1), .pass_cnt(pc1), .fail_cnt(fc1)
    );

    always #5 clk = ~clk;

    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    int n_checks = 0;
    int n_fail = 0;

    // Reference state: sampled history of sig_in and, per build, time of last rise.
    bit hist[0:SYNC];
    int edge_t = 0;
    bit armed_m[2];
    int last_m[2];
    int lastper_m[2];
    bit tmo_m[2];
    int pc_m[2];
    int fc_m[2];
    bit pend_p[2];
    bit pend_f[2];

    function automatic logic [W-1:0] item(bit v, bit p, bit f, bit t, int per);
        logic [CNT_W-1:0] pw;
        pw = per[CNT_W-1:0];
        return {v, p, f, t, pw};
    endfunction

    task automatic push(input int i, input logic [W-1:0] x);
        if (i == 0) exp_q0.push_back(x);
        else exp_q1.push_back(x);
    endtask

    task automatic chk(input string name, input longint act, input longint exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // A rise reaches the period logic SYNC edges after sig_in is first sampled high.
    task automatic model_loop();
        bit r;
        bit ok;
        int tol;
        int per;
        forever begin
            @(posedge clk);
            edge_t++;
            r = hist[SYNC-1] & ~hist[SYNC];
            if (rst) begin
                for (int k = 0; k <= SYNC; k++) hist[k] = 1'b0;
                for (int i = 0; i < 2; i++) begin
                    armed_m[i] = 0; lastper_m[i] = 0; tmo_m[i] = 0;
                    pc_m[i] = 0; fc_m[i] = 0; pend_p[i] = 0; pend_f[i] = 0;
                end
            end else begin
                for (int k = SYNC; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = sig_in;
                for (int i = 0; i < 2; i++) begin
                    tol = i;
                    if (pend_p[i] && pc_m[i] < STAT_MAX) pc_m[i]++;
                    if (pend_f[i] && fc_m[i] < STAT_MAX) fc_m[i]++;
                    pend_p[i] = 0;
                    pend_f[i] = 0;
                    if (!en) begin
                        armed_m[i] = 0;
                    end else if (r) begin
                        if (armed_m[i]) begin
                            per = edge_t - last_m[i];
                            ok = (per >= EXP - tol) && (per <= EXP + tol);
                            lastper_m[i] = per;
                            push(i, item(1'b1, ok, !ok, tmo_m[i], per));
                            pend_p[i] = ok;
                            pend_f[i] = !ok;
                        end
                        armed_m[i] = 1;
                        last_m[i] = edge_t;
                    end else if (armed_m[i] && (edge_t - last_m[i] == EXP + tol)) begin
                        tmo_m[i] = 1;
                        armed_m[i] = 0;
                        pend_f[i] = 1;
                        push(i, item(1'b0, 1'b0, 1'b1, 1'b1, lastper_m[i]));
                    end
                end
            end
        end
    endtask

    task automatic mon_one(input int i, input logic [W-1:0] act);
        bit pulse;
        bit have;
        logic [W-1:0] e;
        pulse = act[W-1] | act[W-2] | act[W-3];
        have = 0;
        e = '0;
        if (i == 0 && exp_q0.size() > 0) begin have = 1; e = exp_q0.pop_front(); end
        if (i == 1 && exp_q1.size() > 0) begin have = 1; e = exp_q1.pop_front(); end
        if (pulse || have) begin
            n_checks++;
            if (!have) begin
                n_fail++;
                $display("FAIL dut%0d unexpected pulse: got %h expected none", i, act);
            end else if (act !== e) begin
                n_fail++;
                $display("FAIL dut%0d pulse {vld,pass,fail,tmo,period}: got %h expected %h", i, act, e);
            end
        end
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            mon_one(0, {vld0, pass0, fail0, tmo0, per0});
            mon_one(1, {vld1, pass1, fail1, tmo1, per1});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic gen_period(input int p, input int n);
        repeat (n) begin
            sig_in = 1'b1;
            idle(p / 2);
            sig_in = 1'b0;
            idle(p - p / 2);
        end
    endtask

    task automatic rand_phase();
        int p;
        int h;
        p = $urandom_range(4, 14);
        h = $urandom_range(1, p - 1);
        if ($urandom_range(0, 9) == 0) en = ~en;
        if ($urandom_range(0, 24) == 0) begin
            rst = 1'b1;
            idle(1);
            rst = 1'b0;
        end
        sig_in = 1'b1;
        idle(h);
        sig_in = 1'b0;
        idle(p - h);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " period_o0"}, per0, 0);
        chk({tag, " period_vld0"}, vld0, 0);
        chk({tag, " pass_pulse0"}, pass0, 0);
        chk({tag, " fail_pulse0"}, fail0, 0);
        chk({tag, " timeout_o0"}, tmo0, 0);
        chk({tag, " pass_cnt0"}, pc0, 0);
        chk({tag, " fail_cnt0"}, fc0, 0);
        chk({tag, " period_o1"}, per1, 0);
        chk({tag, " timeout_o1"}, tmo1, 0);
        chk({tag, " pass_cnt1"}, pc1, 0);
    endtask

    task automatic check_stats(input string tag);
        chk({tag, " pass_cnt0"}, pc0, pc_m[0]);
        chk({tag, " fail_cnt0"}, fc0, fc_m[0]);
        chk({tag, " pass_cnt1"}, pc1, pc_m[1]);
        chk({tag, " fail_cnt1"}, fc1, fc_m[1]);
        chk({tag, " timeout_o0"}, tmo0, tmo_m[0]);
        chk({tag, " timeout_o1"}, tmo1, tmo_m[1]);
        chk({tag, " period_o0"}, per0, lastper_m[0] % (1 << CNT_W));
        chk({tag, " period_o1"}, per1, lastper_m[1] % (1 << CNT_W));
    endtask

    initial begin
        fork
            model_loop();
            monitor_loop();
        join_none

        idle(3);
        check_zero("reset");
        rst = 1'b0;

        // Nominal 10-cycle period: first rise arms, then nine passes.
        gen_period(10, 10);
        chk("s1 pass_cnt0", pc0, 9);
        chk("s1 fail_cnt0", fc0, 0);
        chk("s1 period_o0", per0, 10);
        chk("s1 timeout_o0", tmo0, 0);
        check_stats("s1");

        // Short period of 8.
        gen_period(8, 2);
        chk("s2 period_o0", per0, 8);
        chk("s2 fail_cnt0", fc0, 1);
        check_stats("s2");

        // Stuck low, then recover.
        idle(15);
        chk("s3 timeout_o0", tmo0, 1);
        chk("s3 fail_cnt0", fc0, 2);
        gen_period(10, 2);
        check_stats("s3");

        // Periods 9, 11, 12: the TOL=1 build passes 9 and 11, times out on 12.
        gen_period(9, 1);
        gen_period(11, 1);
        gen_period(12, 1);
        gen_period(10, 1);
        chk("s4 period_o1", per1, 11);
        chk("s4 timeout_o1", tmo1, 1);
        check_stats("s4");

        // Reset mid-period.
        sig_in = 1'b1;
        idle(3);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        sig_in = 1'b0;
        check_zero("s5");
        gen_period(10, 3);
        chk("s5 pass_cnt0", pc0, 2);
        check_stats("s5");

        // Disabled across three rises, then re-enabled.
        en = 1'b0;
        gen_period(10, 3);
        chk("s6 pass_cnt0 disabled", pc0, 2);
        en = 1'b1;
        gen_period(10, 2);
        chk("s6 pass_cnt0", pc0, 3);
        check_stats("s6");

        repeat (60) rand_phase();
        en = 1'b1;
        check_stats("rand");

        // Drive enough good periods to saturate the pass counter.
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        gen_period(10, 262);
        chk("sat pass_cnt0", pc0, STAT_MAX);
        check_stats("sat");

        idle(20);
        check_stats("final");
        chk("final queue0 empty", exp_q0.size(), 0);
        chk("final queue1 empty", exp_q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
